// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the requester arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ahb_arb_pick.sv
// One-hot request picker: rotating priority when AHB_ARB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority with the lowest index winning.
module ahb_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] idx;

  // Search begins one past the previous winner and wraps around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_lite_req_arbiter.sv
// Single AHB-Lite master multiplexing NUM_REQ valid/ready requesters onto one
// slave, one SINGLE transfer at a time. Optional macro: AHB_ARB_ROUND_ROBIN_EN.
module ahb_lite_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]  req_size,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  hsel,
  output logic [AW-1:0]         haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [DW-1:0]         hwdata,
  input  logic [DW-1:0]         hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0] win;
  logic [IW-1:0]      last_grant;
  logic               accept;

  logic               sel_write;
  logic [AW-1:0]      sel_addr;
  logic [2:0]         sel_size;
  logic [DW-1:0]      sel_wdata;

  logic [NUM_REQ-1:0] gnt_oh_q;
  logic               write_q;
  logic [AW-1:0]      addr_q;
  logic [2:0]         size_q;
  logic [DW-1:0]      wdata_q;

  ahb_arb_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (win)
  );

  // Requests are only taken in IDLE and never while reset is held.
  assign accept    = (state_q == IDLE) && (|req_valid) && !hreset;
  assign req_ready = accept ? win : '0;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_size  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_size  = req_size[i*3 +: 3];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = IW'(i);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset)      last_grant_q <= IW'(NUM_REQ - 1);
    else if (accept) last_grant_q <= win_idx;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = IW'(NUM_REQ - 1);
`endif

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hsel    = 1'b0;
    htrans  = HTRANS_IDLE;
    haddr   = '0;
    hwrite  = 1'b0;
    hsize   = '0;
    hburst  = HBURST_SINGLE;
    hprot   = HPROT_DEFAULT;
    hwdata  = '0;
    case (state_q)
      IDLE: if (accept) state_d = ADDR;
      ADDR: begin
        hsel    = 1'b1;
        htrans  = HTRANS_NONSEQ;
        haddr   = addr_q;
        hwrite  = write_q;
        hsize   = size_q;
        state_d = DATA;
      end
      DATA: begin
        hwdata = write_q ? wdata_q : '0;
        if (hready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture stage: fields are only consumed in ADDR/DATA, so no reset.
  always_ff @(posedge hclk) begin
    if (accept) begin
      gnt_oh_q <= win;
      write_q  <= sel_write;
      addr_q   <= sel_addr;
      size_q   <= sel_size;
      wdata_q  <= sel_wdata;
    end
  end

  // Completion stage: an ERROR first cycle (hready=0) simply acts as a wait.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (state_q == DATA && hready) begin
        rsp_valid <= gnt_oh_q;
        rsp_rdata <= write_q ? '0 : hrdata;
        rsp_err   <= hresp;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_req_arbiter.sv
// Directed bench for ahb_lite_req_arbiter (NUM_REQ=2); expectations follow
// AHB_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_ahb_lite_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;

  logic                  hclk = 1'b0;
  logic                  hreset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*3-1:0]  req_size;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;
  logic                  hsel;
  logic [AW-1:0]         haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DW-1:0]         hwdata;
  logic [DW-1:0]         hrdata;
  logic                  hready;
  logic                  hresp;

  int checks = 0;
  int errors = 0;

  ahb_lite_req_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .hclk(hclk), .hreset(hreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    @(negedge hclk);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [2:0] s, input logic [DW-1:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_size[i*3 +: 3]    = s;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    hreset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
    req_size = '0; req_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    repeat (3) tick();
    settle();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    checks++; if (htrans !== 2'b00 || hsel !== 1'b0) begin errors++; $display("FAIL rst_htrans_hsel: got %b/%b want 00/0", htrans, hsel); end
    checks++; if (haddr !== 32'h0 || hwrite !== 1'b0 || hsize !== 3'd0) begin errors++; $display("FAIL rst_addr_ctl: got %h/%b/%0d want 0/0/0", haddr, hwrite, hsize); end
    checks++; if (hburst !== 3'd0 || hprot !== 4'b0011) begin errors++; $display("FAIL rst_burst_prot: got %b/%b want 000/0011", hburst, hprot); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h want 0", hwdata); end
    tick();
    hreset = 1'b0;
  endtask

  task automatic test_single_write();
    tick();
    set_req(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    settle();
    checks++; if (htrans !== 2'b10 || hsel !== 1'b1) begin errors++; $display("FAIL wr_addr_phase: got %b/%b want 10/1", htrans, hsel); end
    checks++; if (haddr !== 32'h10 || hwrite !== 1'b1 || hsize !== 3'd2) begin errors++; $display("FAIL wr_addr_fields: got %h/%b/%0d want 10/1/2", haddr, hwrite, hsize); end
    checks++; if (hburst !== 3'd0 || hprot !== 4'b0011) begin errors++; $display("FAIL wr_burst_prot: got %b/%b want 000/0011", hburst, hprot); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL wr_ready_in_addr: got %b want 00", req_ready); end
    tick();
    settle();
    checks++; if (htrans !== 2'b00 || hsel !== 1'b0) begin errors++; $display("FAIL wr_data_phase: got %b/%b want 00/0", htrans, hsel); end
    checks++; if (hwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hwdata: got %h want deadbeef", hwdata); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_early_rsp: got %b want 00", rsp_valid); end
    tick();
    settle();
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got %b/%b want 01/0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata: got %h want 0", rsp_rdata); end
  endtask

  task automatic test_read_wait();
    tick();
    set_req(1, 1'b0, 32'h10, 3'd1, 32'h0);
    req_valid = 2'b10;
    settle();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_ready: got %b want 10", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_pulse_width: got %b want 00", rsp_valid); end
    tick();
    req_valid = 2'b00;
    settle();
    checks++; if (htrans !== 2'b10 || haddr !== 32'h10 || hwrite !== 1'b0 || hsize !== 3'd1) begin errors++; $display("FAIL rd_addr_phase: got %b/%h/%b/%0d want 10/10/0/1", htrans, haddr, hwrite, hsize); end
    tick();
    hready = 1'b0;
    settle();
    checks++; if (htrans !== 2'b00 || hwdata !== 32'h0) begin errors++; $display("FAIL rd_data_phase: got %b/%h want 00/0", htrans, hwdata); end
    tick();
    settle();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_wait1_rsp: got %b want 00", rsp_valid); end
    tick();
    hready = 1'b1;
    hrdata = 32'hDEADBEEF;
    settle();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_wait2_rsp: got %b want 00", rsp_valid); end
    tick();
    hrdata = 32'h0;
    settle();
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp: got %b/%b want 10/0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp_rdata: got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] exp_g [4];
    logic [NUM_REQ-1:0] g;
    logic [AW-1:0]      exp_a;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    tick();
    set_req(0, 1'b0, 32'h100, 3'd2, 32'h0);
    set_req(1, 1'b0, 32'h200, 3'd2, 32'h0);
    req_valid = 2'b11;
    settle();
    for (int n = 0; n < 4; n++) begin
      checks++; if (req_ready !== exp_g[n]) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", n, req_ready, exp_g[n]); end
      g     = exp_g[n];
      exp_a = g[1] ? 32'h200 : 32'h100;
      tick();
      settle();
      checks++; if (haddr !== exp_a || htrans !== 2'b10) begin errors++; $display("FAIL cont_addr%0d: got %h/%b want %h/10", n, haddr, htrans, exp_a); end
      tick();
      hrdata = 32'h1000 + 32'(n);
      settle();
      tick();
      settle();
      checks++; if (rsp_valid !== g) begin errors++; $display("FAIL cont_rsp%0d: got %b want %b", n, rsp_valid, g); end
      checks++; if (rsp_rdata !== 32'h1000 + 32'(n)) begin errors++; $display("FAIL cont_rdata%0d: got %h want %h", n, rsp_rdata, 32'h1000 + 32'(n)); end
    end
    req_valid = 2'b00;
    hrdata = 32'h0;
  endtask

  task automatic test_error();
    tick();
    set_req(0, 1'b1, 32'h40, 3'd2, 32'h12345678);
    req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL err_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    settle();
    tick();
    hready = 1'b0;
    hresp  = 1'b1;
    settle();
    checks++; if (htrans !== 2'b00 || hwdata !== 32'h12345678) begin errors++; $display("FAIL err_data_phase: got %b/%h want 00/12345678", htrans, hwdata); end
    tick();
    hready = 1'b1;
    settle();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL err_first_cycle_rsp: got %b want 00", rsp_valid); end
    tick();
    hresp = 1'b0;
    settle();
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin errors++; $display("FAIL err_rsp: got %b/%b want 01/1", rsp_valid, rsp_err); end
  endtask

  task automatic test_reset_in_data();
    tick();
    set_req(0, 1'b1, 32'h80, 3'd2, 32'hCAFEF00D);
    set_req(1, 1'b0, 32'h84, 3'd2, 32'h0);
    req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstd_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    settle();
    tick();
    hready = 1'b0;
    settle();
    checks++; if (hwdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rstd_in_data: got %h want cafef00d", hwdata); end
    hreset = 1'b1;
    tick();
    req_valid = 2'b11;
    hready = 1'b1;
    settle();
    checks++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0) begin errors++; $display("FAIL rstd_rsp: got %b/%b want 00/0", rsp_valid, rsp_err); end
    checks++; if (htrans !== 2'b00 || hsel !== 1'b0 || hwdata !== 32'h0) begin errors++; $display("FAIL rstd_bus_idle: got %b/%b/%h want 00/0/0", htrans, hsel, hwdata); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rstd_ready_held: got %b want 00", req_ready); end
    tick();
    hreset = 1'b0;
    settle();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstd_no_late_rsp: got %b want 00", rsp_valid); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstd_first_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_error();
    test_reset_in_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_req_arbiter.md
# ahb_lite_req_arbiter

Shares the single AHB-Lite slave (`amba_ahb_slave`) between `NUM_REQ` simple valid/ready requesters by acting as the one bus master in front of it. Selects one pending request, runs one AHB-Lite SINGLE transfer as an address phase followed by a data phase, then returns read data and error status to the requester that issued the request. Sits between on-chip requesters and the slave's `hsel/haddr/htrans/...` inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8
- `AW`, 32: haddr width
- `DW`, 32: hwdata/hrdata width
- `hclk` input 1: clock, rising edge
- `hreset` input 1: synchronous, active-high reset
- `req_valid` input NUM_REQ: per-requester transfer request
- `req_ready` output NUM_REQ: one-hot; request accepted on this edge
- `req_write` input NUM_REQ: 1 = write, 0 = read
- `req_addr` input NUM_REQ*AW: packed; slice i belongs to requester i
- `req_size` input NUM_REQ*3: packed hsize per requester
- `req_wdata` input NUM_REQ*DW: packed write data
- `rsp_valid` output NUM_REQ: one-hot, one-cycle completion pulse
- `rsp_rdata` output DW: read data, valid with rsp_valid
- `rsp_err` output 1: slave returned ERROR, valid with rsp_valid
- `hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata` output 1/AW/2/1/3/3/4/DW: AHB-Lite master signals to the slave
- `hrdata, hready, hresp` input DW/1/1: from the slave

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any `req_valid`, the arbiter picks winner g and drives `req_ready[g]`=1 combinationally. On that edge it registers g and g's write/addr/size/wdata, then goes to ADDR. Otherwise it stays in IDLE.
- ADDR (exactly one cycle) drives:
  - hsel=1, htrans=NONSEQ (2'b10), hburst=SINGLE (3'b000), hprot=4'b0011
  - haddr/hwrite/hsize from the registered request
  - next state is DATA.
- DATA drives:
  - htrans=IDLE (2'b00), hsel=0
  - hwdata = registered wdata (writes only; 0 on reads)
  - stays in DATA while hready=0.
- Completion: on the DATA cycle with hready=1, the arbiter captures hrdata and hresp. Next cycle: rsp_valid[g]=1, rsp_rdata=captured hrdata (0 for writes), rsp_err=captured hresp. FSM returns to IDLE on the same edge.
- Error response: the first ERROR cycle (hresp=1, hready=0) is treated as a wait state. Completion happens on the second cycle (hresp=1, hready=1) with rsp_err=1.
- hsize is forwarded unchanged. The arbiter does not check address alignment.
- A requester keeps its request stable while `req_valid`=1 and `req_ready`=0. Dropping valid before it is granted is legal. The request is simply not considered.

## Timing
- Minimum latency: request seen in IDLE at cycle t → ADDR t+1 → DATA t+2 (hready=1) → rsp_valid at t+3. Each wait state adds one cycle.
- Peak throughput is one transfer every 3 cycles. The next grant can be in the same cycle as rsp_valid, since the FSM is already in IDLE then.
- Reset values:
  - FSM=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - htrans=IDLE, hsel=0, haddr=0, hwrite=0, hsize=0, hburst=0, hprot=4'b0011, hwdata=0
  - last-grant pointer=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-transfer (ADDR or DATA): the transfer is abandoned, no rsp_valid is issued, and all outputs take their reset values on the next edge.
- If the requester that was just served asserts a new request in the same cycle as its rsp_valid, it competes normally.

## Configuration
- `AHB_ARB_ROUND_ROBIN_EN` defined: rotating priority. The search starts at index (last_grant+1) mod NUM_REQ. last_grant updates on every accepted request.
- Undefined: fixed priority, lowest index wins. The pointer register is not implemented.

## Structure
- Package `ahb_arb_pkg` holds:
  - HTRANS_IDLE/NONSEQ constants, HBURST_SINGLE, HPROT_DEFAULT (4'b0011)
  - the FSM state enum `arb_state_t`.
- Sub-module `ahb_arb_pick`: combinational NUM_REQ-wide picker. Inputs are `req_valid` and `last_grant`; output is the one-hot winner. It implements both the round-robin and fixed-priority modes under the macro.

## Test plan
- Single write: requester 0 writes 0xDEADBEEF to 0x10, size=2, hready=1 → NONSEQ at t+1 with haddr=0x10; hwdata=0xDEADBEEF at t+2; rsp_valid=2'b01 at t+3 with rsp_err=0.
- Read with waits: requester 1 reads 0x10 while the slave holds hready=0 for 2 cycles → rsp_valid=2'b10 at t+5 with rsp_rdata=0xDEADBEEF.
- Contention (round robin): both requesters hold req_valid for 4 transfers → grants go 0,1,0,1. Without the macro → 0,0,0,0 while requester 0 stays valid.
- Error: the slave returns ERROR (hresp=1/hready=0, then hresp=1/hready=1) → one wait cycle, then rsp_err=1 with rsp_valid.
- Reset in DATA: assert hreset in the DATA cycle → no rsp_valid; next cycle htrans=IDLE, hsel=0, req_ready=0; the first grant after reset goes to requester 0.
